// File: rtl/f8_mem_arbiter.sv
// f8_mem_arbiter: shares one byte-wide synchronous-read memory between a
// 24-bit fetch port, a 16-bit data read port and a 16-bit data write port.
//
// Ports:
//   clk, reset (async, active-low)
//   i_req/i_addr    -> i_data[23:0]/i_valid  : 3-byte little-endian fetch
//   dr_req/dr_addr  -> dr_data[15:0]/dr_valid: 2-byte little-endian read
//   dw_req/dw_addr/dw_data -> dw_done        : 2-byte little-endian write
//   mem_addr/mem_wdata/mem_we, mem_rdata     : byte memory, 1-cycle read
//   busy                                     : not IDLE
module f8_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [23:0]       i_data,
  output logic              i_valid,
  input  logic              dr_req,
  input  logic [ADDR_W-1:0] dr_addr,
  output logic [15:0]       dr_data,
  output logic              dr_valid,
  input  logic              dw_req,
  input  logic [ADDR_W-1:0] dw_addr,
  input  logic [15:0]       dw_data,
  output logic              dw_done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DREAD,
    DWRITE,
    CAPTURE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              fetch_q, fetch_d;
  logic [15:0]       buf_q, buf_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       i_data_q, i_data_d;
  logic [15:0]       dr_data_q, dr_data_d;
  logic              i_valid_q, i_valid_d;
  logic              dr_valid_q, dr_valid_d;
  logic              dw_done_q, dw_done_d;

  logic              force_f;
  logic              gnt_f;
  logic              gnt_d;
  logic [1:0]        last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      fetch_q    <= 1'b0;
      buf_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      i_data_q   <= '0;
      dr_data_q  <= '0;
      i_valid_q  <= 1'b0;
      dr_valid_q <= 1'b0;
      dw_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      fetch_q    <= fetch_d;
      buf_q      <= buf_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      i_data_q   <= i_data_d;
      dr_data_q  <= dr_data_d;
      i_valid_q  <= i_valid_d;
      dr_valid_q <= dr_valid_d;
      dw_done_q  <= dw_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    fetch_d    = fetch_q;
    buf_d      = buf_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    i_data_d   = i_data_q;
    dr_data_d  = dr_data_q;
    i_valid_d  = 1'b0;
    dr_valid_d = 1'b0;
    dw_done_d  = 1'b0;
    force_f    = 1'b0;
    gnt_f      = 1'b0;
    gnt_d      = 1'b0;
    // index of the last address cycle: 2 for fetch, 1 for data read
    last       = fetch_q ? 2'd2 : 2'd1;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        force_f = i_req &&
                  (starve_q == SW'(STARVE_MAX));
        if (force_f) begin
          gnt_f = 1'b1;
        end else if (dw_req) begin
          gnt_d   = 1'b1;
          state_d = DWRITE;
          addr_d  = dw_addr;
          wdata_d = dw_data;
        end else if (dr_req) begin
          gnt_d   = 1'b1;
          state_d = DREAD;
          addr_d  = dr_addr;
          fetch_d = 1'b0;
        end else if (i_req) begin
          gnt_f = 1'b1;
        end

        if (gnt_f) begin
          state_d  = FETCH;
          addr_d   = i_addr;
          fetch_d  = 1'b1;
          starve_d = '0;
        end else if (gnt_d) begin
          if (!i_req) begin
            starve_d = '0;
          end else if (starve_q < SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end

      FETCH, DREAD: begin
        // mem_rdata carries the byte addressed one cycle earlier
        if (cnt_q == 2'd1) buf_d[7:0]  = mem_rdata;
        if (cnt_q == 2'd2) buf_d[15:8] = mem_rdata;
        if (cnt_q == last) begin
          state_d = CAPTURE;
        end else begin
          cnt_d  = cnt_q + 2'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      CAPTURE: begin
        // final byte is merged straight from the memory bus
        state_d = IDLE;
        if (fetch_q) begin
          i_data_d  = {mem_rdata, buf_q};
          i_valid_d = 1'b1;
        end else begin
          dr_data_d  = {mem_rdata, buf_q[7:0]};
          dr_valid_d = 1'b1;
        end
      end

      DWRITE: begin
        if (cnt_q == 2'd0) begin
          cnt_d  = 2'd1;
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          state_d   = IDLE;
          dw_done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_we    = (state_q == DWRITE);
    mem_wdata = 8'h00;
    if (mem_we) begin
      mem_wdata = (cnt_q == 2'd0) ? wdata_q[7:0]
                                  : wdata_q[15:8];
    end
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign i_data   = i_data_q;
  assign i_valid  = i_valid_q;
  assign dr_data  = dr_data_q;
  assign dr_valid = dr_valid_q;
  assign dw_done  = dw_done_q;

endmodule

// File: tb/tb_f8_mem_arbiter.sv
// tb_f8_mem_arbiter: randomized and directed bench for f8_mem_arbiter
// against a transaction-level model of arbitration and memory contents.
module tb_f8_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic [23:0] i_data;
  logic        i_valid;
  logic        dr_req;
  logic [15:0] dr_addr;
  logic [15:0] dr_data;
  logic        dr_valid;
  logic        dw_req;
  logic [15:0] dw_addr;
  logic [15:0] dw_data;
  logic        dw_done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        busy;

  logic        ld_en;
  logic [15:0] ld_a;
  logic [7:0]  ld_d;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int n_chk;
  int n_pass;
  int m_starve;

  always #5 clk = ~clk;

  f8_mem_arbiter #(
    .ADDR_W    (16),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .dr_req   (dr_req),
    .dr_addr  (dr_addr),
    .dr_data  (dr_data),
    .dr_valid (dr_valid),
    .dw_req   (dw_req),
    .dw_addr  (dw_addr),
    .dw_data  (dw_data),
    .dw_done  (dw_done),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a,
                      input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    ref_mem[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // 0 = write, 1 = data read, 2 = fetch
  function automatic int pick(bit w, bit r, bit i, int st);
    if (i && st == STARVE) return 2;
    if (w) return 0;
    if (r) return 1;
    if (i) return 2;
    return -1;
  endfunction

  function automatic int nxt_starve(int win, bit i, int st);
    if (win == 2 || !i) return 0;
    return (st < STARVE) ? st + 1 : STARVE;
  endfunction

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 7) == 0)
      return 16'hFFFE + 16'($urandom_range(0, 1));
    return 16'h0100 + 16'($urandom_range(0, 15));
  endfunction

  function automatic logic [23:0] rd_word(input logic [15:0] b,
                                          input int n);
    logic [23:0] v;
    logic [15:0] a;
    v = '0;
    for (int k = 0; k < n; k++) begin
      a = b + 16'(k);
      v[8*k +: 8] = ref_mem[a];
    end
    return v;
  endfunction

  // Called at a negedge with the block idle. Raises the chosen
  // requests together and drops each one in its completion cycle.
  task automatic round(input bit w, input bit r, input bit i,
                       input logic [15:0] wa,
                       input logic [15:0] wd,
                       input logic [15:0] ra,
                       input logic [15:0] ia,
                       input string tag);
    bit          pend [3];
    int          order [$];
    int          exp_t [3];
    logic [23:0] exp_v [3];
    logic [15:0] e_addr [64];
    bit          e_we [64];
    logic [7:0]  e_wd [64];
    bit          e_busy [64];
    logic [15:0] a;
    logic [15:0] base;
    int t, win, n, done, bad, t_end;

    pend[0] = w;
    pend[1] = r;
    pend[2] = i;
    t = 0;
    while (pend[0] || pend[1] || pend[2]) begin
      win = pick(pend[0], pend[1], pend[2], m_starve);
      m_starve = nxt_starve(win, pend[2], m_starve);
      order.push_back(win);
      pend[win] = 1'b0;
      if (win == 0) begin
        a = wa + 16'd1;
        e_addr[t]   = wa; e_we[t]   = 1; e_wd[t]   = wd[7:0];
        e_busy[t]   = 1;
        e_addr[t+1] = a;  e_we[t+1] = 1; e_wd[t+1] = wd[15:8];
        e_busy[t+1] = 1;
        e_addr[t+2] = a;  e_we[t+2] = 0; e_wd[t+2] = 0;
        e_busy[t+2] = 0;
        ref_mem[wa] = wd[7:0];
        ref_mem[a]  = wd[15:8];
        exp_t[0] = t + 2;
        t += 3;
      end else begin
        n    = (win == 2) ? 3 : 2;
        base = (win == 2) ? ia : ra;
        exp_v[win] = rd_word(base, n);
        a = base;
        for (int k = 0; k < n; k++) begin
          a = base + 16'(k);
          e_addr[t+k] = a; e_we[t+k] = 0; e_wd[t+k] = 0;
          e_busy[t+k] = 1;
        end
        e_addr[t+n]   = a; e_we[t+n]   = 0; e_wd[t+n]   = 0;
        e_busy[t+n]   = 1;
        e_addr[t+n+1] = a; e_we[t+n+1] = 0; e_wd[t+n+1] = 0;
        e_busy[t+n+1] = 0;
        exp_t[win] = t + n + 1;
        t += n + 2;
      end
    end
    t_end = t - 1;

    dw_req = w; dw_addr = wa; dw_data = wd;
    dr_req = r; dr_addr = ra;
    i_req  = i; i_addr  = ia;
    pend[0] = w;
    pend[1] = r;
    pend[2] = i;
    done = 0;
    bad  = 0;
    t    = -1;
    while ((pend[0] || pend[1] || pend[2]) && t < 60) begin
      step();
      t++;
      if (t <= t_end) begin
        if (mem_addr !== e_addr[t] || mem_we !== e_we[t] ||
            busy !== e_busy[t] ||
            (e_we[t] && mem_wdata !== e_wd[t]))
          bad++;
      end
      if (dw_done && !pend[0]) bad++;
      if (dr_valid && !pend[1]) bad++;
      if (i_valid && !pend[2]) bad++;
      if (dw_done && pend[0]) begin
        chk({tag, "_ord"}, 0,
            (done < order.size()) ? order[done] : -1);
        chk({tag, "_dw_t"}, t, exp_t[0]);
        done++;
        pend[0] = 1'b0;
        dw_req  = 1'b0;
      end
      if (dr_valid && pend[1]) begin
        chk({tag, "_ord"}, 1,
            (done < order.size()) ? order[done] : -1);
        chk({tag, "_dr_t"}, t, exp_t[1]);
        chk({tag, "_dr_v"}, dr_data, exp_v[1][15:0]);
        done++;
        pend[1] = 1'b0;
        dr_req  = 1'b0;
      end
      if (i_valid && pend[2]) begin
        chk({tag, "_ord"}, 2,
            (done < order.size()) ? order[done] : -1);
        chk({tag, "_if_t"}, t, exp_t[2]);
        chk({tag, "_if_v"}, i_data, exp_v[2]);
        done++;
        pend[2] = 1'b0;
        i_req   = 1'b0;
      end
    end
    chk({tag, "_bus"}, bad, 0);
    chk({tag, "_left"},
        int'(pend[0]) + int'(pend[1]) + int'(pend[2]), 0);
  endtask

  initial begin
    int          k;
    int          t;
    int          exp;
    logic [2:0]  m;

    n_chk = 0; n_pass = 0; m_starve = 0;
    reset = 1'b1;
    i_req = 0; i_addr = 0; dr_req = 0; dr_addr = 0;
    dw_req = 0; dw_addr = 0; dw_data = 0;
    ld_en = 0; ld_a = 0; ld_d = 0;

    #2 reset = 1'b0;
    #1;
    chk("por_ctl", {busy, mem_we, i_valid, dr_valid, dw_done}, 0);
    chk("por_addr", mem_addr, 0);
    chk("por_data", {i_data, dr_data}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int a = 0; a < 18; a++)
      poke(16'h0100 + 16'(a), 8'($urandom));
    poke(16'hFFFE, 8'($urandom));
    poke(16'h0001, 8'($urandom));
    poke(16'h0010, 8'h11);
    poke(16'h0011, 8'h22);
    poke(16'h0012, 8'h33);

    @(negedge clk);
    round(0, 0, 1, 0, 0, 0, 16'h0010, "fetch");
    chk("fetch_val", i_data, 24'h332211);

    @(negedge clk);
    round(1, 0, 0, 16'h0020, 16'hBEEF, 0, 0, "wr");
    @(negedge clk);
    round(0, 1, 0, 0, 0, 16'h0020, 0, "rdback");
    chk("rdback_val", dr_data, 16'hBEEF);

    poke(16'hFFFF, 8'h34);
    poke(16'h0000, 8'h12);
    @(negedge clk);
    round(0, 1, 0, 0, 0, 16'hFFFF, 0, "wrap");
    chk("wrap_val", dr_data, 16'h1234);

    @(negedge clk);
    round(1, 1, 1, 16'h0102, 16'h5AC3, 16'h0102,
          16'h0101, "simul");

    // reset in the middle of a fetch
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0010;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    m_starve = 0;
    #1;
    chk("rst_ctl", {busy, mem_we, i_valid, dr_valid, dw_done}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_idata", i_data, 0);
    chk("rst_drdata", dr_data, 0);
    chk("rst_wdata", mem_wdata, 0);
    repeat (2) begin
      step();
      chk("rst_hold", {i_valid, busy}, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    round(0, 0, 1, 0, 0, 0, 16'h0010, "rst_fetch");
    chk("rst_fval", i_data, 24'h332211);

    // both readers held: guard forces fetch periodically
    @(negedge clk);
    dr_req = 1'b1; dr_addr = 16'h0104;
    i_req  = 1'b1; i_addr  = 16'h0108;
    k = 0;
    t = 0;
    while (k < 10 && t < 200) begin
      step();
      t++;
      if (dr_valid || i_valid) begin
        exp = pick(0, 1, 1, m_starve);
        m_starve = nxt_starve(exp, 1, m_starve);
        chk($sformatf("starve_seq%0d", k), i_valid ? 2 : 1, exp);
        if (i_valid)
          chk("starve_if_v", i_data, rd_word(16'h0108, 3));
        else
          chk("starve_dr_v", dr_data, rd_word(16'h0104, 2));
        k++;
        if (k == 10) begin
          dr_req = 1'b0;
          i_req  = 1'b0;
        end
      end
    end
    chk("starve_cnt", k, 10);

    for (int n = 0; n < 40; n++) begin
      m = 3'($urandom_range(1, 7));
      @(negedge clk);
      round(m[0], m[1], m[2], rnd_addr(), 16'($urandom),
            rnd_addr(), rnd_addr(), $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/f8_mem_arbiter.md
Name: f8_mem_arbiter

Overview:
Shares one single-port, byte-wide, synchronous-read memory between three CPU access streams: 24-bit instruction fetch, 16-bit data read and 16-bit data write. The block sequences the multi-byte accesses, assembles and splits words little-endian, and arbitrates with fixed priority plus a starvation guard for fetch. It sits between cpu and a byte-wide memory in the test system.

Parameters:
ADDR_W, 16, address width; byte addresses wrap modulo 2^ADDR_W.
STARVE_MAX, 4, consecutive data grants allowed while i_req is pending before fetch is forced (>=1).

Ports:
clk  in  1  system clock, posedge.
reset  in  1  asynchronous, active-low reset.
i_req  in  1  fetch request; hold until i_valid.
i_addr  in  ADDR_W  fetch byte address.
i_data  out  24  fetched instruction, {b2,b1,b0}.
i_valid  out  1  one-cycle pulse: i_data valid.
dr_req  in  1  data read request.
dr_addr  in  ADDR_W  data read byte address.
dr_data  out  16  read word, {b1,b0}.
dr_valid  out  1  one-cycle pulse: dr_data valid.
dw_req  in  1  data write request.
dw_addr  in  ADDR_W  data write byte address.
dw_data  in  16  write word.
dw_done  out  1  one-cycle pulse: write complete.
mem_addr  out  ADDR_W  memory byte address.
mem_rdata  in  8  memory read data, valid one cycle after mem_addr.
mem_wdata  out  8  memory write data.
mem_we  out  1  memory write enable.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, async): state IDLE, all outputs 0, i_data/dr_data 0, byte counter and starve counter 0. A transaction in flight is aborted; a partially written word is permitted and is not rolled back.
- States: IDLE, FETCH, DREAD, DWRITE, CAPTURE.
- IDLE arbitration at each posedge (edge E0): priority dw_req > dr_req > i_req, except when starve_cnt == STARVE_MAX and i_req is high, in which case fetch wins. Address (and dw_data) are latched at grant; later changes to inputs are ignored.
- starve_cnt: increments on a data grant while i_req is high and saturates at STARVE_MAX; clears on a fetch grant or when a grant occurs with i_req low.
- Read (n = 3 fetch, 2 dread): in cycle k after E0 (k = 0..n-1), mem_addr = base+k (ADDR_W wrap). Byte k is captured at edge E(k+1). After the last address cycle the state is CAPTURE. At E(n+1) the block loads the assembled word, pulses i_valid/dr_valid for exactly one cycle, and returns to IDLE.
- Latency: fetch valid is high in the cycle after E4; dread valid is high in the cycle after E3.
- Write: in cycle 0 drive mem_we=1, mem_addr=base, mem_wdata=dw_data[7:0]. In cycle 1 drive mem_we=1, mem_addr=base+1, mem_wdata=dw_data[15:8]. At E2 pulse dw_done for one cycle and return to IDLE.
- mem_we is 0 in all other states. mem_addr holds its last value when idle.
- The state is IDLE during a valid/done pulse cycle. A requester still asserting req in that cycle starts a new transaction, so a requester that wants no further access must drop req in the pulse cycle.
- At most one transaction is in flight at a time. Requests not granted wait indefinitely, subject only to the starvation guard.
- i_data/dr_data hold their value until the next completion of the same type.

Test Plan:
- Reset: assert reset low mid-FETCH (after E1) -> all outputs 0 immediately with no i_valid. After release, the held i_req restarts the fetch from byte 0.
- Fetch: mem[0x0010..0x0012] = 11,22,33, i_req with i_addr=0x0010 -> mem_addr 0x0010/0x0011/0x0012 on consecutive cycles, i_valid pulse after E4, i_data = 0x332211.
- Write then read back: dw 0x0020 <- 0xBEEF -> mem_we on 2 cycles (0x0020:EF, 0x0021:BE), dw_done after E2. A subsequent dr at 0x0020 gives dr_data = 0xBEEF after E3.
- Simultaneous: dw_req, dr_req and i_req raised in the same cycle, each dropped on its own pulse -> completion order dw_done, dr_valid, i_valid. busy stays high throughout except for one IDLE cycle between transactions.
- Wrap: dr at 0xFFFF with mem[0xFFFF]=0x34, mem[0x0000]=0x12 -> mem_addr 0xFFFF then 0x0000, dr_data = 0x1234.
- Starvation: dr_req and i_req held high continuously -> exactly 4 dread grants, then 1 fetch grant, then the pattern repeats. Also check starve_cnt clear after the fetch grant.
